// File: rtl/bus_responder_pkg.sv
// Shared types for the byte-wide req/ack bus responder.
package bus_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALO,
        ALO_W,
        AHI,
        AHI_W,
        DAT,
        DAT_W
    } state_t;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

endpackage

// File: rtl/bus_sync.sv
// Multi-bit flop-chain synchroniser, cleared to zero on reset.
module bus_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_responder.sv
// Target side of the 4-phase byte bus: addr lo, addr hi, data -> one backend access.
// States: IDLE, ALO/ALO_W (addr lo), AHI/AHI_W (addr hi, read prefetch), DAT/DAT_W (data).
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic        ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    logic [2:0] sync_q;
    logic       sreq;
    logic       srd;
    logic       swr;
    state_t     state;
    logic       kind;
    logic       rd_valid;
    logic       armed;
    logic       abort;

    bus_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({req, rd, wr}),
        .q   (sync_q)
    );

    assign {sreq, srd, swr} = sync_q;

    // A transaction that began without any kind flag cannot signal an initiator reset.
    assign abort = !sreq && !srd && !swr && armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= 1'b0;
            bus_oe    <= 1'b0;
            bus_out   <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            err       <= 1'b0;
            kind      <= KIND_RD;
            rd_valid  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            if (mem_req && mem_ack && kind == KIND_RD && (state == AHI_W || state == DAT)) begin
                bus_out  <= mem_rdata;
                rd_valid <= 1'b1;
                mem_req  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sreq) state <= ALO;
                end
                ALO: begin
                    mem_addr[7:0] <= bus_in;
                    kind          <= swr ? KIND_WR : KIND_RD;
                    armed         <= srd | swr;
                    rd_valid      <= 1'b0;
                    if (srd == swr) err <= 1'b1;
                    ack           <= 1'b1;
                    state         <= ALO_W;
                end
                ALO_W: begin
                    if (!sreq) begin
                        ack   <= 1'b0;
                        state <= AHI;
                    end
                end
                AHI: begin
                    if (sreq) begin
                        mem_addr[15:8] <= bus_in;
                        ack            <= 1'b1;
                        if (kind == KIND_RD) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                        state <= AHI_W;
                    end else if (abort) begin
                        ack     <= 1'b0;
                        bus_oe  <= 1'b0;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                AHI_W: begin
                    if (!sreq) begin
                        ack   <= 1'b0;
                        state <= DAT;
                    end
                end
                DAT: begin
                    if (abort) begin
                        ack      <= 1'b0;
                        bus_oe   <= 1'b0;
                        mem_req  <= 1'b0;
                        rd_valid <= 1'b0;
                        state    <= IDLE;
                    end else if (kind == KIND_WR) begin
                        if (mem_req) begin
                            if (mem_ack) begin
                                mem_req <= 1'b0;
                                ack     <= 1'b1;
                                state   <= DAT_W;
                            end
                        end else if (sreq) begin
                            mem_wdata <= bus_in;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                        end
                    end else if (sreq && (rd_valid || (mem_req && mem_ack))) begin
                        bus_oe <= 1'b1;
                        ack    <= 1'b1;
                        state  <= DAT_W;
                    end
                end
                DAT_W: begin
                    if (!sreq) begin
                        ack      <= 1'b0;
                        bus_oe   <= 1'b0;
                        rd_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
